bsg_clz_normalize_pipe: RTL and testbench
=========================================

Name: bsg_clz_normalize_pipe

Overview:
- Pipelined, parametrised leading-zero counter and normalizer for arbitrary width.
- Per accepted operand it returns three things: the leading-zero count, an all-zero flag and the operand left-shifted so its MSB is 1.
- Count range is 0..width_p inclusive; the all-zero case is width_p, not truncated.
- Sits in front of FP/int normalization paths; ready/valid in, valid/yumi out, so it drops into existing bsg pipelines.

Parameters:
- width_p, 16, operand width; any value >= 2, not restricted to powers of two.
- stages_p, 2, pipeline register stages; legal range 1..clog2(width_p).
- count_width_lp, clog2(width_p+1), derived; width of count_o.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  input operand valid.
- data_i  in  width_p  operand.
- ready_o  out  1  block can accept an operand this cycle.
- v_o  out  1  result valid.
- count_o  out  count_width_lp  leading-zero count, 0..width_p.
- zero_o  out  1  operand was all zeros.
- norm_o  out  width_p  data_i << count, zero-filled from the LSB.
- yumi_i  in  1  consumer takes the result; legal only when v_o=1.

Behaviour:
- Algorithm:
  - Pad the operand on the right with zeros to P = 2^clog2(width_p).
  - Binary-search normalizer with k = clog2(P) steps, one step per shift size P/2, P/4, ..., 1.
  - Each step: if the top s bits are all zero, shift left by s and set that count bit.
  - Steps are spread across stages_p register stages: stage j performs steps ceil(j*k/stages_p) .. ceil((j+1)*k/stages_p)-1.
- Output formation:
  - The last step's count sees a zero top bit when the operand is all zeros; zero_o is carried from an input-side OR-reduce.
  - When zero_o=1, count_o is forced to width_p and norm_o is 0.
  - Otherwise count_o is the accumulated count minus nothing; the padding sits below the data and does not affect leading zeros.
- Latency: exactly stages_p cycles from a v_i&ready_o accept to v_o, when there is no back-pressure.
- Throughput: one operand per cycle while yumi_i is held high.
- Each stage holds its own valid bit.
  - Stage n loads when it is empty, or when its contents advance this cycle.
  - The last stage advances on yumi_i.
  - ready_o = ~stage0_valid | stage0_advances. The combinational yumi_i -> ready_o path is allowed.
- v_o is the last-stage valid. count_o, zero_o and norm_o hold stable while v_o=1 and yumi_i=0.
- Reset (reset_n_i low, asynchronous assert, synchronous deassert by the integrator):
  - All stage valids clear, so v_o=0.
  - Data registers clear to 0, so count_o=0, zero_o=0, norm_o=0.
  - ready_o=1 from the first cycle after reset release.
  - Reset mid-operation discards all in-flight operands; no result emerges for them.
- Simultaneous accept and yumi with the pipe full: accepted, no bubble, order preserved.
- yumi_i while v_o=0: illegal; the block ignores it (no state change).
- Inputs with v_i=0 are don't-care and must not change any output.

Optional Feature:
- Macro: BSG_CLZ_NORMALIZE_PIPE_PERF_EN.
- Defined:
  - Adds outputs ops_cnt_o [31:0] and zero_cnt_o [31:0].
  - ops_cnt_o counts yumi_i handshakes; zero_cnt_o counts yumi_i handshakes with zero_o=1.
  - Both reset to 0 on reset_n_i low and wrap at 2^32 (0xFFFFFFFF -> 0).
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. width_p=16, stages_p=2; reset, then v_i=1, data_i=16'h0001 with yumi_i=1 -> v_o=1 exactly 2 cycles later, count_o=15, zero_o=0, norm_o=16'h8000.
2. width_p=16; data_i=16'h0000 -> count_o=16, zero_o=1, norm_o=0. Then data_i=16'h8000 -> count_o=0, norm_o=16'h8000.
3. width_p=12 (non-power-of-two), stages_p=3; data_i=12'h00F -> count_o=8, norm_o=12'hF00; data_i=12'h000 -> count_o=12, zero_o=1.
4. Back-pressure: stream 0x0100, 0x0010, 0x0001 with yumi_i=0 for 4 cycles.
   - ready_o drops to 0 after stages_p operands are held.
   - v_o stays 1 with count_o=7 stable.
   - Release yumi_i -> counts 7, 11, 15 in order, one per cycle, none lost or duplicated.
5. Reset mid-stream: pull reset_n_i low with 2 operands in flight -> v_o=0 immediately and all outputs 0. After release, the next input 16'h0400 yields only count_o=5.
6. With BSG_CLZ_NORMALIZE_PIPE_PERF_EN defined: 5 handshakes, 2 of them all-zero -> ops_cnt_o=5, zero_cnt_o=2. Preload ops_cnt_o to 0xFFFFFFFF via force, one more handshake -> 0.

Source files
------------

// File: rtl/bsg_clz_normalize_pipe.sv
// bsg_clz_normalize_pipe
// Pipelined leading-zero counter and normalizer for any operand width >= 2.
// Input side is ready/valid and output side is valid/yumi. A binary-search
// normalizer is split across stages_p register stages. Each stage has its own
// valid bit, so the pipe can stall without dropping or duplicating operands.
// Optional: define BSG_CLZ_NORMALIZE_PIPE_PERF_EN to add the handshake
// counters ops_cnt_o and zero_cnt_o.
module bsg_clz_normalize_pipe #(
    parameter  int width_p        = 16,
    parameter  int stages_p       = 2,
    localparam int count_width_lp = $clog2(width_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [count_width_lp-1:0] count_o,
    output logic                      zero_o,
    output logic [width_p-1:0]        norm_o,
    input  logic                      yumi_i
`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
    ,
    output logic [31:0]               ops_cnt_o,
    output logic [31:0]               zero_cnt_o
`endif
);

    // Number of binary-search steps. The padded width is 2**steps_lp.
    localparam int steps_lp = $clog2(width_p);

    // Runs search steps lo..hi-1 on one operand. Shift sizes are P/2 .. 1,
    // where P is the padded width. The zero padding on the right is never
    // stored. Every shift size is at most P/2, which is less than width_p.
    // So the "top s bits zero" test only looks at real data bits, and the
    // zero fill on a left shift gives the same result as shifting the
    // padding in.
    function automatic logic [steps_lp+width_p-1:0] norm_steps(
        input logic [width_p-1:0]  data,
        input logic [steps_lp-1:0] cnt,
        input int                  lo,
        input int                  hi
    );
        logic [width_p-1:0]  d;
        logic [steps_lp-1:0] c;
        int                  s;
        d = data;
        c = cnt;
        s = 0;
        for (int i = 0; i < steps_lp; i++) begin
            if (i >= lo && i < hi) begin
                s = (1 << steps_lp) >> (i + 1);
                if ((d >> (width_p - s)) == '0) begin
                    d = d << s;
                    c[steps_lp-1-i] = 1'b1;
                end
            end
        end
        return {c, d};
    endfunction

    for (genvar j = 0; j < stages_p; j++) begin : g_stage
        // Stage j runs search steps ceil(j*k/stages_p) .. ceil((j+1)*k/stages_p)-1.
        localparam int lo_lp = (j * steps_lp + stages_p - 1) / stages_p;
        localparam int hi_lp = ((j + 1) * steps_lp + stages_p - 1) / stages_p;

        logic                v_r;
        logic                zero_r;
        logic [width_p-1:0]  data_r;
        logic [steps_lp-1:0] cnt_r;

        logic                adv;
        logic                load;
        logic                in_v;
        logic                in_zero;
        logic [width_p-1:0]  in_data;
        logic [steps_lp-1:0] in_cnt;
        logic [width_p-1:0]  nxt_data;
        logic [steps_lp-1:0] nxt_cnt;

        if (j == 0) begin : g_src_in
            assign in_v    = v_i;
            assign in_zero = ~|data_i;
            assign in_data = data_i;
            assign in_cnt  = '0;
        end else begin : g_src_prev
            assign in_v    = g_stage[j-1].v_r;
            assign in_zero = g_stage[j-1].zero_r;
            assign in_data = g_stage[j-1].data_r;
            assign in_cnt  = g_stage[j-1].cnt_r;
        end

        if (j == stages_p - 1) begin : g_adv_last
            assign adv = v_r & yumi_i;
        end else begin : g_adv_mid
            assign adv = v_r & g_stage[j+1].load;
        end

        assign load                = ~v_r | adv;
        assign {nxt_cnt, nxt_data} = norm_steps(in_data, in_cnt, lo_lp, hi_lp);

        // Stage register: the valid bit follows the upstream valid on every
        // load. The payload only loads when the incoming slot is valid, so
        // idle inputs never disturb the stored result.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                v_r    <= 1'b0;
                zero_r <= 1'b0;
                data_r <= '0;
                cnt_r  <= '0;
            end else if (load) begin
                v_r <= in_v;
                if (in_v) begin
                    zero_r <= in_zero;
                    data_r <= nxt_data;
                    cnt_r  <= nxt_cnt;
                end
            end
        end
    end

    assign ready_o = g_stage[0].load;
    assign v_o     = g_stage[stages_p-1].v_r;
    assign zero_o  = g_stage[stages_p-1].zero_r;

    // An all-zero operand reports the full width as its count, not the
    // saturated search count.
    assign count_o = zero_o ? count_width_lp'(width_p)
                            : count_width_lp'(g_stage[stages_p-1].cnt_r);
    assign norm_o  = zero_o ? '0 : g_stage[stages_p-1].data_r;

`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
    logic [31:0] ops_cnt_r;
    logic [31:0] zero_cnt_r;

    // Count output handshakes, and separately the handshakes for all-zero
    // operands. Both counters wrap naturally at 2**32.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ops_cnt_r  <= '0;
            zero_cnt_r <= '0;
        end else if (v_o & yumi_i) begin
            ops_cnt_r <= ops_cnt_r + 32'd1;
            if (zero_o) begin
                zero_cnt_r <= zero_cnt_r + 32'd1;
            end
        end
    end

    assign ops_cnt_o  = ops_cnt_r;
    assign zero_cnt_o = zero_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_clz_normalize_pipe.sv
// tb_bsg_clz_normalize_pipe
// Uses two instances: 16-bit with 2 stages, and 12-bit with 3 stages.
// A negedge monitor pushes model results when an operand is accepted and
// records DUT results on each output handshake. Each test task checks its
// own results inline.
// Define BSG_CLZ_NORMALIZE_PIPE_PERF_EN to also exercise the counters.
module tb_bsg_clz_normalize_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic        a_v, a_ready, a_vo, a_zero, a_yumi;
    logic [15:0] a_data, a_norm;
    logic [4:0]  a_count;

    logic        b_v, b_ready, b_vo, b_zero, b_yumi;
    logic [11:0] b_data, b_norm;
    logic [3:0]  b_count;

`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
    logic [31:0] a_ops, a_zcnt, b_ops, b_zcnt;
`endif

    bsg_clz_normalize_pipe #(.width_p(16), .stages_p(2)) dut_a (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (a_v),
        .data_i    (a_data),
        .ready_o   (a_ready),
        .v_o       (a_vo),
        .count_o   (a_count),
        .zero_o    (a_zero),
        .norm_o    (a_norm),
        .yumi_i    (a_yumi)
`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
        ,
        .ops_cnt_o (a_ops),
        .zero_cnt_o(a_zcnt)
`endif
    );

    bsg_clz_normalize_pipe #(.width_p(12), .stages_p(3)) dut_b (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (b_v),
        .data_i    (b_data),
        .ready_o   (b_ready),
        .v_o       (b_vo),
        .count_o   (b_count),
        .zero_o    (b_zero),
        .norm_o    (b_norm),
        .yumi_i    (b_yumi)
`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
        ,
        .ops_cnt_o (b_ops),
        .zero_cnt_o(b_zcnt)
`endif
    );

    // Scoreboard entries are {count, zero, norm}.
    logic [21:0] exp_a [$];
    logic [21:0] got_a [$];
    logic [16:0] exp_b [$];
    logic [16:0] got_b [$];

    // Reference count: scan down from the MSB.
    function automatic int clz_ref(input logic [15:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return w - 1 - i;
        end
        return w;
    endfunction

    function automatic logic [21:0] model_a(input logic [15:0] d);
        int          c;
        logic [15:0] n;
        c = clz_ref(d, 16);
        n = (c == 16) ? 16'h0 : (d << c);
        return {5'(c), (c == 16), n};
    endfunction

    function automatic logic [16:0] model_b(input logic [11:0] d);
        int          c;
        logic [11:0] n;
        c = clz_ref({4'h0, d}, 12);
        n = (c == 12) ? 12'h0 : (d << c);
        return {4'(c), (c == 12), n};
    endfunction

    // Push the expected result on each accept and the observed result on
    // each output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_v && a_ready) exp_a.push_back(model_a(a_data));
            if (a_vo && a_yumi) got_a.push_back({a_count, a_zero, a_norm});
            if (b_v && b_ready) exp_b.push_back(model_b(b_data));
            if (b_vo && b_yumi) got_b.push_back({b_count, b_zero, b_norm});
        end
    end

    task automatic idle_inputs();
        a_v = 1'b0; a_data = 16'h0; a_yumi = 1'b0;
        b_v = 1'b0; b_data = 12'h0; b_yumi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_vo, a_count, a_zero, a_norm} !== 23'h0) begin
            bad++;
            $display("[TB] FAIL reset_a_outputs got=%h want=0", {a_vo, a_count, a_zero, a_norm});
        end
        total++;
        if ({b_vo, b_count, b_zero, b_norm} !== 18'h0) begin
            bad++;
            $display("[TB] FAIL reset_b_outputs got=%h want=0", {b_vo, b_count, b_zero, b_norm});
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_a_ready got=%b want=1", a_ready);
        end
        total++;
        if (b_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_b_ready got=%b want=1", b_ready);
        end
    endtask

    task automatic test_single();
        logic [21:0] g, e;
        a_v = 1'b1; a_data = 16'h0001; a_yumi = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0;
        total++;
        if (a_vo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_early_vo got=%b want=0", a_vo);
        end
        @(posedge clk); #1;
        total++;
        if ({a_vo, a_count, a_zero, a_norm} !== {1'b1, 5'd15, 1'b0, 16'h8000}) begin
            bad++;
            $display("[TB] FAIL single_result got v=%b c=%0d z=%b n=%h want v=1 c=15 z=0 n=8000",
                     a_vo, a_count, a_zero, a_norm);
        end
        @(posedge clk); #1;
        a_yumi = 1'b0;
        total++;
        if (a_vo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_drain_vo got=%b want=0", a_vo);
        end
        total++;
        if (got_a.size() != 1) begin
            bad++;
            $display("[TB] FAIL single_count got=%0d want=1", got_a.size());
        end
        while (got_a.size() != 0 && exp_a.size() != 0) begin
            g = got_a.pop_front(); e = exp_a.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("[TB] FAIL single_sb got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_zero_msb();
        logic [21:0] g, e;
        a_v = 1'b1; a_data = 16'h0000; a_yumi = 1'b1;
        @(posedge clk); #1;
        a_data = 16'h8000;
        @(posedge clk); #1;
        a_v = 1'b0;
        total++;
        if ({a_vo, a_count, a_zero, a_norm} !== {1'b1, 5'd16, 1'b1, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL zero_result got v=%b c=%0d z=%b n=%h want v=1 c=16 z=1 n=0000",
                     a_vo, a_count, a_zero, a_norm);
        end
        @(posedge clk); #1;
        total++;
        if ({a_vo, a_count, a_zero, a_norm} !== {1'b1, 5'd0, 1'b0, 16'h8000}) begin
            bad++;
            $display("[TB] FAIL msb_result got v=%b c=%0d z=%b n=%h want v=1 c=0 z=0 n=8000",
                     a_vo, a_count, a_zero, a_norm);
        end
        @(posedge clk); #1;
        a_yumi = 1'b0;
        total++;
        if (got_a.size() != 2) begin
            bad++;
            $display("[TB] FAIL zero_msb_count got=%0d want=2", got_a.size());
        end
        while (got_a.size() != 0 && exp_a.size() != 0) begin
            g = got_a.pop_front(); e = exp_a.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("[TB] FAIL zero_msb_sb got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_width12();
        logic [16:0] g, e;
        b_v = 1'b1; b_data = 12'h00F; b_yumi = 1'b1;
        @(posedge clk); #1;
        b_data = 12'h000;
        @(posedge clk); #1;
        b_v = 1'b0;
        total++;
        if (b_vo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL w12_early_vo got=%b want=0", b_vo);
        end
        @(posedge clk); #1;
        total++;
        if ({b_vo, b_count, b_zero, b_norm} !== {1'b1, 4'd8, 1'b0, 12'hF00}) begin
            bad++;
            $display("[TB] FAIL w12_result got v=%b c=%0d z=%b n=%h want v=1 c=8 z=0 n=f00",
                     b_vo, b_count, b_zero, b_norm);
        end
        @(posedge clk); #1;
        total++;
        if ({b_vo, b_count, b_zero, b_norm} !== {1'b1, 4'd12, 1'b1, 12'h000}) begin
            bad++;
            $display("[TB] FAIL w12_zero got v=%b c=%0d z=%b n=%h want v=1 c=12 z=1 n=000",
                     b_vo, b_count, b_zero, b_norm);
        end
        @(posedge clk); #1;
        b_yumi = 1'b0;
        total++;
        if (got_b.size() != 2) begin
            bad++;
            $display("[TB] FAIL w12_count got=%0d want=2", got_b.size());
        end
        while (got_b.size() != 0 && exp_b.size() != 0) begin
            g = got_b.pop_front(); e = exp_b.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("[TB] FAIL w12_sb got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [21:0] g, e;
        a_v = 1'b1; a_data = 16'h0100; a_yumi = 1'b0;
        @(posedge clk); #1;
        a_data = 16'h0010;
        @(posedge clk); #1;
        a_data = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_ready cycle=%0d got=%b want=0", i, a_ready);
            end
            total++;
            if ({a_vo, a_count} !== {1'b1, 5'd7}) begin
                bad++;
                $display("[TB] FAIL bp_hold cycle=%0d got v=%b c=%0d want v=1 c=7", i, a_vo, a_count);
            end
            @(posedge clk); #1;
        end
        a_yumi = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0;
        total++;
        if ({a_vo, a_count} !== {1'b1, 5'd11}) begin
            bad++;
            $display("[TB] FAIL bp_second got v=%b c=%0d want v=1 c=11", a_vo, a_count);
        end
        @(posedge clk); #1;
        total++;
        if ({a_vo, a_count} !== {1'b1, 5'd15}) begin
            bad++;
            $display("[TB] FAIL bp_third got v=%b c=%0d want v=1 c=15", a_vo, a_count);
        end
        @(posedge clk); #1;
        a_yumi = 1'b0;
        total++;
        if (a_vo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_empty got=%b want=0", a_vo);
        end
        total++;
        if (got_a.size() != 3) begin
            bad++;
            $display("[TB] FAIL bp_count got=%0d want=3", got_a.size());
        end
        while (got_a.size() != 0 && exp_a.size() != 0) begin
            g = got_a.pop_front(); e = exp_a.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("[TB] FAIL bp_sb got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] g, e;
        a_v = 1'b1; a_data = 16'h0001; a_yumi = 1'b0;
        @(posedge clk); #1;
        a_data = 16'h0002;
        @(posedge clk); #1;
        a_v = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_vo, a_count, a_zero, a_norm} !== 23'h0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs got=%h want=0", {a_vo, a_count, a_zero, a_norm});
        end
        exp_a.delete();
        got_a.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b1; a_data = 16'h0400; a_yumi = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a_yumi = 1'b0;
        total++;
        if (got_a.size() != 1) begin
            bad++;
            $display("[TB] FAIL midreset_count got=%0d want=1", got_a.size());
        end
        if (got_a.size() != 0 && exp_a.size() != 0) begin
            g = got_a.pop_front(); e = exp_a.pop_front();
            total++;
            if (g[21:17] !== 5'd5) begin
                bad++;
                $display("[TB] FAIL midreset_value got=%0d want=5", g[21:17]);
            end
            total++;
            if (g !== e) begin
                bad++;
                $display("[TB] FAIL midreset_sb got=%h want=%h", g, e);
            end
        end
        exp_a.delete();
        got_a.delete();
    endtask

    task automatic test_random();
        logic [21:0] ga, ea;
        logic [16:0] gb, eb;
        int sent_a, sent_b, cyc;
        localparam int n_ops = 40;
        sent_a = 0; sent_b = 0; cyc = 0;
        while ((got_a.size() < n_ops || got_b.size() < n_ops) && cyc < 2000) begin
            a_v    = (sent_a < n_ops) && ($urandom_range(0, 3) != 0);
            a_data = 16'($urandom >> $urandom_range(16, 32));
            a_yumi = a_vo && ($urandom_range(0, 2) != 0);
            b_v    = (sent_b < n_ops) && ($urandom_range(0, 3) != 0);
            b_data = 12'($urandom >> $urandom_range(20, 32));
            b_yumi = b_vo && ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (a_v && a_ready) sent_a++;
            if (b_v && b_ready) sent_b++;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        total++;
        if (got_a.size() != n_ops) begin
            bad++;
            $display("[TB] FAIL random_a_count got=%0d want=%0d", got_a.size(), n_ops);
        end
        total++;
        if (got_b.size() != n_ops) begin
            bad++;
            $display("[TB] FAIL random_b_count got=%0d want=%0d", got_b.size(), n_ops);
        end
        while (got_a.size() != 0 && exp_a.size() != 0) begin
            ga = got_a.pop_front(); ea = exp_a.pop_front();
            total++;
            if (ga !== ea) begin
                bad++;
                $display("[TB] FAIL random_a_sb got=%h want=%h", ga, ea);
            end
        end
        while (got_b.size() != 0 && exp_b.size() != 0) begin
            gb = got_b.pop_front(); eb = exp_b.pop_front();
            total++;
            if (gb !== eb) begin
                bad++;
                $display("[TB] FAIL random_b_sb got=%h want=%h", gb, eb);
            end
        end
    endtask

`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
    task automatic test_perf();
        logic [15:0] vals [5];
        vals[0] = 16'h0000; vals[1] = 16'h0005; vals[2] = 16'h0000;
        vals[3] = 16'h0007; vals[4] = 16'h0009;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        a_yumi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_v = 1'b1; a_data = vals[i];
            @(posedge clk); #1;
        end
        a_v = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_yumi = 1'b0;
        total++;
        if (a_ops !== 32'd5) begin
            bad++;
            $display("[TB] FAIL perf_ops got=%0d want=5", a_ops);
        end
        total++;
        if (a_zcnt !== 32'd2) begin
            bad++;
            $display("[TB] FAIL perf_zero got=%0d want=2", a_zcnt);
        end
        force dut_a.ops_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut_a.ops_cnt_r;
        a_v = 1'b1; a_data = 16'h0003; a_yumi = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_yumi = 1'b0;
        total++;
        if (a_ops !== 32'd0) begin
            bad++;
            $display("[TB] FAIL perf_wrap got=%h want=0", a_ops);
        end
        exp_a.delete();
        got_a.delete();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_zero_msb();
        test_width12();
        test_back_pressure();
        test_reset_mid();
        test_random();
`ifdef BSG_CLZ_NORMALIZE_PIPE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
